led_bar_monitor: RTL and testbench
==================================

# led_bar_monitor

Passive observer on the 16-bit LED bar driven by the bound flasher. Each clock it decodes the bar as a thermometer code into a level, tracks rise/fall direction with a small FSM, latches turn-around peaks and valleys, and flags illegal codes and multi-step jumps. It sits beside the flasher in the same clock domain, both in simulation as a self-check and in silicon as a status source.

## Interface
- `WIDTH`, default 16: number of LEDs observed.
- `LVL_W`, default 5: level width; must satisfy 2^LVL_W > WIDTH.
- `CNT_W`, default 8: event counter width; used only with the configuration macro.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `led` in WIDTH: bar from the flasher, sampled on every rising edge.
- `level` out LVL_W: decoded lit count, 0..WIDTH.
- `dir` out 2: 00 IDLE, 01 RISE, 10 FALL; 11 never driven.
- `turn` out 1: one-cycle pulse on a direction reversal.
- `peak` out LVL_W: level at the most recent RISE→FALL reversal.
- `valley` out LVL_W: level at the most recent FALL→RISE reversal.
- `restart` out 1: one-cycle pulse when the bar jumps to 0 from a level ≥ 2.
- `code_err` out 1: one-cycle pulse when `led` is not a thermometer code.
- `step_err` out 1: one-cycle pulse on a legal nonzero jump with |Δ| > 1.
- `err_sticky` out 1: set by `code_err` or `step_err`; cleared only by `rst`.
- `turn_cnt`, `err_cnt` out CNT_W: event counters (see Configuration).

## Operation
- Legal code: `led[k-1:0]` all ones and the upper bits all zero, for k = 0..WIDTH. The decoded level is k.
- Each edge compares the new level against `level_q`. Δ = new − old.
- Illegal code: `code_err` pulses. `level`, `dir`, `peak` and `valley` hold.
- Δ = 0: no change.
- Δ = +1:
  - From IDLE, go to RISE.
  - From FALL, go to RISE, pulse `turn`, and set `valley` to the old level.
  - From RISE, stay in RISE.
- Δ = −1:
  - From RISE, go to FALL, pulse `turn`, and set `peak` to the old level.
  - From FALL, stay in FALL. If the new level is 0, go to IDLE with no `turn`.
- Jump to 0 from level ≥ 2: `restart` pulses, state goes to IDLE, no `step_err`.
- Other |Δ| > 1: `step_err` pulses, `level` updates, and the state follows the sign of Δ as for ±1. No `turn` and no `peak`/`valley` update.
- Reaching level 0 from RISE (Δ = −1 from 1): go to IDLE, set `peak` to 1, pulse `turn`.
- Reset values: `level` = 0, `dir` = IDLE, `peak` = 0, `valley` = 0, all pulses 0, `err_sticky` = 0, counters 0.

## Timing
- All outputs are registered. A `led` value present before edge n is reflected on the outputs after edge n (latency 1).
- Pulses are high for exactly one cycle, after the edge on which the event was detected.
- Simultaneous events on one edge are not possible (they are exclusive per edge by construction), except `err_sticky`, which sets on the same edge as its pulse.
- `rst` asserted mid-operation clears all state immediately, without waiting for `clk`. The first edge after release compares against level 0. A bar already at level 5 at that point is therefore a jump: `step_err` pulses and `dir` = RISE.
- No handshake. The monitor never stalls and never drives the flasher.

## Configuration
- `LED_BAR_MON_CNT_EN` defined:
  - `turn_cnt` increments on each `turn`.
  - `err_cnt` increments on each `code_err` or `step_err`.
  - Both saturate at 2^CNT_W − 1 and reset to 0.
- Not defined: both counters are tied to 0 and their registers are not built.

## Test plan
- Ramp `led` 0x0000→0x003F one bit per cycle, then back to 0x0000 → `dir` RISE; then `turn`=1 one cycle after 0x001F appears, `peak`=6, `dir` FALL; `dir` IDLE when `level` reaches 0; `step_err`/`code_err` stay 0.
- Kickback: 0x001F→0x000F→0x001F → `turn` twice; `peak`=5, `valley`=4.
- Drive 0x0005 → `code_err` pulses once; `err_sticky`=1; `level` holds its prior value.
- 0x00FF then 0x0000 → `restart`=1, `dir` IDLE, `step_err`=0. Then 0x0007 → `step_err`=1, `level`=3, `dir` RISE.
- Assert `rst` between edges while `level`=10 → all outputs are reset values before the next edge; `err_sticky` clears.
- With `LED_BAR_MON_CNT_EN`, run 300 reversals → `turn_cnt`=255 (saturated). Without the macro, `turn_cnt`=0 throughout.

Source files
------------

// File: rtl/led_bar_monitor.sv
// led_bar_monitor: passive observer of a thermometer-coded LED bar.
// Decodes the bar into a level and tracks its rise/fall direction.
// Latches turn-around peaks and valleys, and flags illegal codes and
// multi-step jumps. The optional event counters are built only when
// LED_BAR_MON_CNT_EN is defined; otherwise they read as zero.
module led_bar_monitor #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LVL_W = 5,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] led,
   output logic [LVL_W-1:0] level,
   output logic [1:0]       dir,
   output logic             turn,
   output logic [LVL_W-1:0] peak,
   output logic [LVL_W-1:0] valley,
   output logic             restart,
   output logic             code_err,
   output logic             step_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] turn_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RISE = 2'b01,
      FALL = 2'b10
   } dir_e;

   dir_e             state_q, state_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [LVL_W-1:0] peak_q, peak_d;
   logic [LVL_W-1:0] valley_q, valley_d;
   logic             turn_q, turn_d;
   logic             restart_q, restart_d;
   logic             code_err_q, code_err_d;
   logic             step_err_q, step_err_d;
   logic             sticky_q, sticky_d;

   logic             legal;
   logic [LVL_W-1:0] new_lvl;

   // Decode: a thermometer code has no set bit above a clear bit, i.e. led+1 is a power of two.
   always_comb begin
      legal   = ((led & (led + WIDTH'(1))) == '0);
      new_lvl = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         new_lvl = new_lvl + LVL_W'(led[i]);
      end
   end

   // Next-state: direction FSM, extrema latching and event pulses.
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      peak_d     = peak_q;
      valley_d   = valley_q;
      turn_d     = 1'b0;
      restart_d  = 1'b0;
      code_err_d = 1'b0;
      step_err_d = 1'b0;
      if (!legal) begin
         code_err_d = 1'b1;
      end else if (new_lvl != level_q) begin
         level_d = new_lvl;
         if (new_lvl == '0 && level_q >= LVL_W'(2)) begin
            restart_d = 1'b1;
            state_d   = IDLE;
         end else if (new_lvl == level_q + LVL_W'(1)) begin
            if (state_q == FALL) begin
               turn_d   = 1'b1;
               valley_d = level_q;
            end
            state_d = RISE;
         end else if (level_q == new_lvl + LVL_W'(1)) begin
            if (state_q == RISE) begin
               turn_d = 1'b1;
               peak_d = level_q;
            end
            state_d = (new_lvl == '0) ? IDLE : FALL;
         end else begin
            step_err_d = 1'b1;
            state_d    = (new_lvl > level_q) ? RISE : FALL;
         end
      end
      sticky_d = sticky_q | code_err_d | step_err_d;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         level_q    <= '0;
         peak_q     <= '0;
         valley_q   <= '0;
         turn_q     <= 1'b0;
         restart_q  <= 1'b0;
         code_err_q <= 1'b0;
         step_err_q <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         peak_q     <= peak_d;
         valley_q   <= valley_d;
         turn_q     <= turn_d;
         restart_q  <= restart_d;
         code_err_q <= code_err_d;
         step_err_q <= step_err_d;
         sticky_q   <= sticky_d;
      end
   end

   assign level      = level_q;
   assign dir        = state_q;
   assign turn       = turn_q;
   assign peak       = peak_q;
   assign valley     = valley_q;
   assign restart    = restart_q;
   assign code_err   = code_err_q;
   assign step_err   = step_err_q;
   assign err_sticky = sticky_q;

`ifdef LED_BAR_MON_CNT_EN
   logic [CNT_W-1:0] turn_cnt_q, turn_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Saturating counters advance on the same edge that registers their pulse.
   always_comb begin
      turn_cnt_d = turn_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (turn_d && turn_cnt_q != '1) begin
         turn_cnt_d = turn_cnt_q + CNT_W'(1);
      end
      if ((code_err_d || step_err_d) && err_cnt_q != '1) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         turn_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         turn_cnt_q <= turn_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign turn_cnt = turn_cnt_q;
   assign err_cnt  = err_cnt_q;
`else
   assign turn_cnt = '0;
   assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_led_bar_monitor.sv
// Scoreboard bench for led_bar_monitor: directed scenarios plus random walk,
// expected outputs from a level-arithmetic reference model.
module tb_led_bar_monitor;
   localparam int WIDTH = 16;
   localparam int LVL_W = 5;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] led = '0;
   logic [LVL_W-1:0] level, peak, valley;
   logic [1:0]       dir;
   logic             turn, restart, code_err, step_err, err_sticky;
   logic [CNT_W-1:0] turn_cnt, err_cnt;

   led_bar_monitor #(.WIDTH(WIDTH), .LVL_W(LVL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .led(led), .level(level), .dir(dir), .turn(turn),
      .peak(peak), .valley(valley), .restart(restart), .code_err(code_err),
      .step_err(step_err), .err_sticky(err_sticky), .turn_cnt(turn_cnt),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int level; int dir; int turn; int peak; int valley; int restart;
      int code_err; int step_err; int sticky; int tcnt; int ecnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cycle = 0;

   // Reference model state (dir: 0 idle, 1 rise, 2 fall).
   int m_level, m_dir, m_peak, m_valley, m_sticky, m_tcnt, m_ecnt;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] thermo(input int k);
      logic [WIDTH:0] t;
      t = ({{WIDTH{1'b0}}, 1'b1} << k) - 1'b1;
      return t[WIDTH-1:0];
   endfunction

   task automatic model_reset();
      m_level = 0; m_dir = 0; m_peak = 0; m_valley = 0;
      m_sticky = 0; m_tcnt = 0; m_ecnt = 0;
   endtask

   task automatic model_step(input logic [WIDTH-1:0] v, output exp_t e);
      int k, d;
      bit ok;
      e = '{default: 0};
      ok = 0;
      k = 0;
      for (int i = 0; i <= WIDTH; i++)
         if (int'(v) == (1 << i) - 1) begin ok = 1; k = i; end
      if (!ok) begin
         e.code_err = 1;
      end else begin
         d = k - m_level;
         if (d == 0) begin
         end else if (k == 0 && m_level >= 2) begin
            e.restart = 1; m_dir = 0;
         end else if (d == 1) begin
            if (m_dir == 2) begin e.turn = 1; m_valley = m_level; end
            m_dir = 1;
         end else if (d == -1) begin
            if (m_dir == 1) begin e.turn = 1; m_peak = m_level; end
            m_dir = (k == 0) ? 0 : 2;
         end else begin
            e.step_err = 1; m_dir = (d > 0) ? 1 : 2;
         end
         m_level = k;
      end
      if (e.code_err || e.step_err) m_sticky = 1;
`ifdef LED_BAR_MON_CNT_EN
      if (e.turn && m_tcnt < CMAX) m_tcnt++;
      if ((e.code_err || e.step_err) && m_ecnt < CMAX) m_ecnt++;
`endif
      e.level = m_level; e.dir = m_dir; e.peak = m_peak; e.valley = m_valley;
      e.sticky = m_sticky; e.tcnt = m_tcnt; e.ecnt = m_ecnt;
   endtask

   task automatic drive(input logic [WIDTH-1:0] v);
      exp_t e;
      @(negedge clk);
      led = v;
      model_step(v, e);
      q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_level"}, int'(level), 0);
      chk({tag, "_dir"}, int'(dir), 0);
      chk({tag, "_peak"}, int'(peak), 0);
      chk({tag, "_valley"}, int'(valley), 0);
      chk({tag, "_pulses"}, int'({turn, restart, code_err, step_err}), 0);
      chk({tag, "_sticky"}, int'(err_sticky), 0);
      chk({tag, "_tcnt"}, int'(turn_cnt), 0);
      chk({tag, "_ecnt"}, int'(err_cnt), 0);
   endtask

   // Asynchronous reset between edges, then present v for the following edge.
   task automatic reset_then(input logic [WIDTH-1:0] v);
      exp_t e;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      #1;
      rst = 1'b0;
      model_reset();
      led = v;
      model_step(v, e);
      q.push_back(e);
   endtask

   // Monitor: one expected entry per registered output update.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("level", int'(level), e.level);
            chk("dir", int'(dir), e.dir);
            chk("turn", int'(turn), e.turn);
            chk("peak", int'(peak), e.peak);
            chk("valley", int'(valley), e.valley);
            chk("restart", int'(restart), e.restart);
            chk("code_err", int'(code_err), e.code_err);
            chk("step_err", int'(step_err), e.step_err);
            chk("err_sticky", int'(err_sticky), e.sticky);
            chk("turn_cnt", int'(turn_cnt), e.tcnt);
            chk("err_cnt", int'(err_cnt), e.ecnt);
         end
      end
   end

   // Watchdog.
   initial begin
      #3000000;
      failures++;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   // Stimulus.
   initial begin
      int r, nl;
      model_reset();
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;

      // Ramp up to 6 and back down to 0.
      for (int k = 1; k <= 6; k++) drive(thermo(k));
      for (int k = 5; k >= 0; k--) drive(thermo(k));
      // Kickback around 5/4.
      for (int k = 1; k <= 5; k++) drive(thermo(k));
      drive(16'h000F);
      drive(16'h001F);
      // Illegal code holds level.
      drive(16'h0005);
      // Restart, then a jump from 0.
      for (int k = 6; k <= 8; k++) drive(thermo(k));
      drive(16'h0000);
      drive(16'h0007);
      // Full bar and beyond.
      for (int k = 4; k <= WIDTH; k++) drive(thermo(k));
      drive(16'h8000);
      // Asynchronous reset at level 10, then a bar at level 5.
      for (int k = 9; k >= 0; k--) drive(thermo(k));
      for (int k = 1; k <= 10; k++) drive(thermo(k));
      reset_then(16'h001F);
      drive(16'h003F);
      // 300 reversals between levels 1 and 2.
      drive(16'h0001);
      for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 16'h0003 : 16'h0001);
      // Random walk.
      for (int i = 0; i < 2000; i++) begin
         r = int'($urandom_range(0, 99));
         nl = m_level;
         if (r < 40) nl = (m_level < WIDTH) ? m_level + 1 : m_level - 1;
         else if (r < 75) nl = (m_level > 0) ? m_level - 1 : 1;
         else if (r < 85) nl = m_level;
         else if (r < 93) nl = int'($urandom_range(0, WIDTH));
         if (r >= 93) drive(WIDTH'($urandom));
         else drive(thermo(nl));
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
